// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter between fetch and memory stages (option: MEMARB_TIMEOUT_EN)
module mem_arbiter #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_flush,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_valid,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_valid,
   output logic              write_done,
   output logic              inst_stall,
   output logic              mem_stall,
   output logic              m_req,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic              m_ack,
   input  logic [DATA_W-1:0] m_rdata,
   output logic              arb_err
);

   typedef enum logic [1:0] {IDLE, D_BUSY, IF_BUSY, IF_DRAIN} state_t;

   state_t state;
   state_t state_next;
   logic   timeout;

   assign if_rdata = m_rdata;
   assign d_rdata  = m_rdata;

`ifdef MEMARB_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT + 1) < 8) ? 8 : $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] wait_cnt;

   // Cycles the current memory request has been outstanding; restarts in IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         wait_cnt <= '0;
      else if (state == IDLE)
         wait_cnt <= '0;
      else
         wait_cnt <= wait_cnt + 1'b1;
   end

   // An ack in the last allowed cycle still completes normally.
   assign timeout = (state != IDLE) && !m_ack && (wait_cnt == CNT_W'(TIMEOUT - 1));

   // Sticky error flag, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         arb_err <= 1'b0;
      else if (timeout)
         arb_err <= 1'b1;
   end
`else
   assign timeout = 1'b0;
   assign arb_err = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Next-state logic: data wins a tie, a flushed fetch drains its ack silently.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (d_req)
               state_next = D_BUSY;
            else if (if_req && !if_flush)
               state_next = IF_BUSY;
         end
         D_BUSY: begin
            if (m_ack || timeout)
               state_next = IDLE;
         end
         IF_BUSY: begin
            if (m_ack || timeout)
               state_next = IDLE;
            else if (if_flush)
               state_next = IF_DRAIN;
         end
         IF_DRAIN: begin
            if (m_ack || timeout)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Completion pulses and stall levels for the pipeline hazard logic.
   always_comb begin
      d_valid  = 1'b0;
      if_valid = 1'b0;
      case (state)
         D_BUSY:  d_valid  = m_ack;
         IF_BUSY: if_valid = m_ack && !if_flush;
         default: ;
      endcase
      write_done = d_valid && m_we;
      inst_stall = if_req && !if_valid;
      mem_stall  = d_req && !d_valid;
   end

   // Memory request registers: captured on grant, held stable until the transaction ends.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_req   <= 1'b0;
         m_we    <= 1'b0;
         m_addr  <= '0;
         m_wdata <= '0;
      end else begin
         m_req <= (state_next != IDLE);
         if (state == IDLE) begin
            if (d_req) begin
               m_we    <= d_we;
               m_addr  <= d_addr;
               m_wdata <= d_wdata;
            end else if (if_req && !if_flush) begin
               m_we   <= 1'b0;
               m_addr <= if_addr;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

   localparam int O_NONE  = 0;
   localparam int O_DATA  = 1;
   localparam int O_FETCH = 2;
   localparam int O_DRAIN = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_req = 1'b0;
   logic [15:0] if_addr = '0;
   logic        if_flush = 1'b0;
   logic [15:0] if_rdata;
   logic        if_valid;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [15:0] d_addr = '0;
   logic [15:0] d_wdata = '0;
   logic [15:0] d_rdata;
   logic        d_valid;
   logic        write_done;
   logic        inst_stall;
   logic        mem_stall;
   logic        m_req;
   logic        m_we;
   logic [15:0] m_addr;
   logic [15:0] m_wdata;
   logic        m_ack = 1'b0;
   logic [15:0] m_rdata = '0;
   logic        arb_err;

   int errors = 0;
   int checks = 0;

   logic [15:0] ref_mem  [16];
   logic [15:0] phys_mem [16];

   mem_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
      .if_rdata(if_rdata), .if_valid(if_valid),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_valid(d_valid), .write_done(write_done),
      .inst_stall(inst_stall), .mem_stall(mem_stall),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_ack(m_ack), .m_rdata(m_rdata), .arb_err(arb_err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL reset_m_req: got %b want 0", m_req); end
      checks++; if (m_we !== 1'b0) begin errors++; $display("FAIL reset_m_we: got %b want 0", m_we); end
      checks++; if (m_addr !== 16'h0000) begin errors++; $display("FAIL reset_m_addr: got %h want 0000", m_addr); end
      checks++; if (m_wdata !== 16'h0000) begin errors++; $display("FAIL reset_m_wdata: got %h want 0000", m_wdata); end
      checks++; if (arb_err !== 1'b0) begin errors++; $display("FAIL reset_arb_err: got %b want 0", arb_err); end
      checks++; if ({if_valid, d_valid, write_done, inst_stall, mem_stall} !== 5'b0) begin
         errors++; $display("FAIL reset_pulses: got %b want 00000", {if_valid, d_valid, write_done, inst_stall, mem_stall});
      end
      step();
      rst_n = 1'b1;
      step();
      #2;
      checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL reset_idle_m_req: got %b want 0", m_req); end
   endtask

   task automatic test_fetch();
      step(); if_req = 1'b1; if_addr = 16'h0010; #2;
      checks++; if (inst_stall !== 1'b1) begin errors++; $display("FAIL fetch_stall_t0: got %b want 1", inst_stall); end
      checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL fetch_latency: got %b want 0", m_req); end
      step(); #2;
      checks++; if (m_req !== 1'b1) begin errors++; $display("FAIL fetch_m_req: got %b want 1", m_req); end
      checks++; if (m_addr !== 16'h0010) begin errors++; $display("FAIL fetch_m_addr: got %h want 0010", m_addr); end
      checks++; if (m_we !== 1'b0) begin errors++; $display("FAIL fetch_m_we: got %b want 0", m_we); end
      for (int i = 0; i < 2; i++) begin
         step(); #2;
         checks++; if ({if_valid, inst_stall} !== 2'b01) begin errors++; $display("FAIL fetch_wait: got %b want 01", {if_valid, inst_stall}); end
      end
      step(); m_ack = 1'b1; m_rdata = 16'hA5A5; #2;
      checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL fetch_valid: got %b want 1", if_valid); end
      checks++; if (if_rdata !== 16'hA5A5) begin errors++; $display("FAIL fetch_rdata: got %h want a5a5", if_rdata); end
      checks++; if (inst_stall !== 1'b0) begin errors++; $display("FAIL fetch_stall_done: got %b want 0", inst_stall); end
      step(); m_ack = 1'b0; if_req = 1'b0; #2;
      checks++; if ({m_req, if_valid, inst_stall} !== 3'b000) begin errors++; $display("FAIL fetch_after: got %b want 000", {m_req, if_valid, inst_stall}); end
   endtask

   task automatic test_simultaneous();
      step(); if_req = 1'b1; if_addr = 16'h0020; d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0030; #2;
      step(); #2;
      checks++; if (m_addr !== 16'h0030) begin errors++; $display("FAIL simul_data_first: got %h want 0030", m_addr); end
      checks++; if (m_we !== 1'b0) begin errors++; $display("FAIL simul_m_we: got %b want 0", m_we); end
      step(); m_ack = 1'b1; m_rdata = 16'h1111; #2;
      checks++; if ({d_valid, if_valid, inst_stall, mem_stall} !== 4'b1010) begin
         errors++; $display("FAIL simul_d_done: got %b want 1010", {d_valid, if_valid, inst_stall, mem_stall});
      end
      checks++; if (d_rdata !== 16'h1111) begin errors++; $display("FAIL simul_d_rdata: got %h want 1111", d_rdata); end
      step(); m_ack = 1'b0; d_req = 1'b0; #2;
      checks++; if ({m_req, inst_stall} !== 2'b01) begin errors++; $display("FAIL simul_idle_gap: got %b want 01", {m_req, inst_stall}); end
      step(); #2;
      checks++; if ({m_req, m_addr, inst_stall} !== {1'b1, 16'h0020, 1'b1}) begin
         errors++; $display("FAIL simul_fetch_grant: got req=%b addr=%h want req=1 addr=0020", m_req, m_addr);
      end
      step(); m_ack = 1'b1; m_rdata = 16'h2222; #2;
      checks++; if ({if_valid, if_rdata} !== {1'b1, 16'h2222}) begin errors++; $display("FAIL simul_fetch_done: got %b/%h want 1/2222", if_valid, if_rdata); end
      step(); m_ack = 1'b0; if_req = 1'b0; #2;
   endtask

   task automatic test_store();
      step(); d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0042; d_wdata = 16'h1234; #2;
      step(); #2;
      checks++; if ({m_req, m_we, m_addr, m_wdata} !== {1'b1, 1'b1, 16'h0042, 16'h1234}) begin
         errors++; $display("FAIL store_req: got we=%b addr=%h wdata=%h want 1/0042/1234", m_we, m_addr, m_wdata);
      end
      step(); m_ack = 1'b1; #2;
      checks++; if ({d_valid, write_done, if_valid} !== 3'b110) begin errors++; $display("FAIL store_done: got %b want 110", {d_valid, write_done, if_valid}); end
      step(); m_ack = 1'b0; d_req = 1'b0; d_we = 1'b0; #2;
      checks++; if ({write_done, d_valid, m_req} !== 3'b000) begin errors++; $display("FAIL store_after: got %b want 000", {write_done, d_valid, m_req}); end
   endtask

   task automatic test_flush();
      step(); if_req = 1'b1; if_addr = 16'h0050; #2;
      step(); if_flush = 1'b1; if_addr = 16'h0060; #2;
      checks++; if ({m_req, m_addr, if_valid} !== {1'b1, 16'h0050, 1'b0}) begin
         errors++; $display("FAIL flush_grant: got req=%b addr=%h valid=%b want 1/0050/0", m_req, m_addr, if_valid);
      end
      step(); if_flush = 1'b0; #2;
      checks++; if ({m_req, m_addr} !== {1'b1, 16'h0050}) begin errors++; $display("FAIL flush_drain_hold: got %b/%h want 1/0050", m_req, m_addr); end
      step(); m_ack = 1'b1; m_rdata = 16'hDEAD; #2;
      checks++; if ({if_valid, inst_stall} !== 2'b01) begin errors++; $display("FAIL flush_no_valid: got %b want 01", {if_valid, inst_stall}); end
      step(); m_ack = 1'b0; #2;
      checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL flush_req_drop: got %b want 0", m_req); end
      step(); #2;
      checks++; if ({m_req, m_addr} !== {1'b1, 16'h0060}) begin errors++; $display("FAIL flush_refetch: got %b/%h want 1/0060", m_req, m_addr); end
      step(); m_ack = 1'b1; m_rdata = 16'hBEEF; #2;
      checks++; if ({if_valid, if_rdata} !== {1'b1, 16'hBEEF}) begin errors++; $display("FAIL flush_refetch_done: got %b/%h want 1/beef", if_valid, if_rdata); end
      step(); m_ack = 1'b0; if_req = 1'b0; #2;
   endtask

   task automatic test_reset_mid();
      step(); d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0077; #2;
      step(); #2;
      checks++; if (m_req !== 1'b1) begin errors++; $display("FAIL rstmid_busy: got %b want 1", m_req); end
      step(); rst_n = 1'b0; m_ack = 1'b1; #1;
      checks++; if ({m_req, d_valid} !== 2'b00) begin errors++; $display("FAIL rstmid_async: got %b want 00", {m_req, d_valid}); end
      d_req = 1'b0; m_ack = 1'b0;
      step(); rst_n = 1'b1; #2;
      step(); m_ack = 1'b1; #2;
      checks++; if ({d_valid, if_valid, write_done} !== 3'b000) begin errors++; $display("FAIL rstmid_late_ack: got %b want 000", {d_valid, if_valid, write_done}); end
      step(); m_ack = 1'b0; #2;
      checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL rstmid_idle: got %b want 0", m_req); end
   endtask

`ifdef MEMARB_TIMEOUT_EN
   task automatic test_timeout();
      step(); d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0099; #2;
      for (int i = 0; i < 4; i++) begin
         step(); #2;
         checks++; if ({m_req, d_valid, arb_err} !== 3'b100) begin errors++; $display("FAIL timeout_wait%0d: got %b want 100", i, {m_req, d_valid, arb_err}); end
      end
      step(); #2;
      checks++; if ({m_req, arb_err, d_valid, mem_stall} !== 4'b0101) begin
         errors++; $display("FAIL timeout_fire: got %b want 0101", {m_req, arb_err, d_valid, mem_stall});
      end
      step(); #2;
      checks++; if ({m_req, m_addr} !== {1'b1, 16'h0099}) begin errors++; $display("FAIL timeout_regrant: got %b/%h want 1/0099", m_req, m_addr); end
      step(); m_ack = 1'b1; #2;
      checks++; if ({d_valid, arb_err} !== 2'b11) begin errors++; $display("FAIL timeout_retry_done: got %b want 11", {d_valid, arb_err}); end
      step(); m_ack = 1'b0; d_req = 1'b0; #2;
      checks++; if ({m_req, arb_err} !== 2'b01) begin errors++; $display("FAIL timeout_sticky: got %b want 01", {m_req, arb_err}); end
   endtask
`else
   task automatic test_timeout();
      step(); d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0099; #2;
      for (int i = 0; i < 10; i++) begin
         step(); #2;
         checks++; if ({m_req, arb_err, d_valid} !== 3'b100) begin errors++; $display("FAIL notimeout_wait%0d: got %b want 100", i, {m_req, arb_err, d_valid}); end
      end
      step(); m_ack = 1'b1; #2;
      checks++; if (d_valid !== 1'b1) begin errors++; $display("FAIL notimeout_done: got %b want 1", d_valid); end
      step(); m_ack = 1'b0; d_req = 1'b0; #2;
   endtask
`endif

   // Random traffic: the reference tracks who owns the memory port and a reference memory image.
   task automatic test_random(input int ncyc);
      int          owner = O_NONE;
      logic [15:0] own_addr = '0;
      logic        own_we = 1'b0;
      logic [15:0] own_wdata = '0;
      logic        f_pend = 1'b0;
      logic [15:0] f_addr = '0;
      logic        dp = 1'b0;
      logic        dw = 1'b0;
      logic [15:0] da = '0;
      logic [15:0] dd = '0;
      int          resp_wait = -1;
      logic        last_if_done = 1'b0;
      logic        last_d_done = 1'b0;
      logic        last_flush = 1'b0;
      logic        exp_mreq, exp_dv, exp_iv, exp_wd;
      for (int i = 0; i < 16; i++) begin
         ref_mem[i]  = 16'(i * 16'h1111) ^ 16'h0F0F;
         phys_mem[i] = ref_mem[i];
      end
      for (int c = 0; c < ncyc; c++) begin
         step();
         if (last_if_done || last_flush) f_pend = 1'b0;
         if (!f_pend && ($urandom_range(1, 0) == 1)) begin f_pend = 1'b1; f_addr = 16'($urandom); end
         if_flush = f_pend && ($urandom_range(5, 0) == 0);
         if_req   = f_pend;
         if_addr  = f_addr;
         if (last_d_done) dp = 1'b0;
         if (!dp && ($urandom_range(2, 0) == 0)) begin
            dp = 1'b1; dw = ($urandom_range(1, 0) == 1); da = 16'($urandom); dd = 16'($urandom);
         end
         d_req = dp; d_we = dw; d_addr = da; d_wdata = dd;
         m_ack = 1'b0;
         m_rdata = 16'($urandom);
         if (m_req) begin
            if (resp_wait < 0) resp_wait = $urandom_range(3, 0);
            if (resp_wait == 0) begin
               m_ack = 1'b1;
               m_rdata = phys_mem[m_addr[3:0]];
               if (m_we) phys_mem[m_addr[3:0]] = m_wdata;
               resp_wait = -1;
            end else begin
               resp_wait--;
            end
         end else begin
            resp_wait = -1;
            m_ack = ($urandom_range(9, 0) == 0);
         end
         #2;
         exp_mreq = (owner != O_NONE);
         exp_dv   = (owner == O_DATA) && m_ack;
         exp_iv   = (owner == O_FETCH) && m_ack && !if_flush;
         exp_wd   = exp_dv && own_we;
         checks++; if (m_req !== exp_mreq) begin errors++; $display("FAIL rnd_m_req c%0d: got %b want %b", c, m_req, exp_mreq); end
         checks++; if (d_valid !== exp_dv) begin errors++; $display("FAIL rnd_d_valid c%0d: got %b want %b", c, d_valid, exp_dv); end
         checks++; if (if_valid !== exp_iv) begin errors++; $display("FAIL rnd_if_valid c%0d: got %b want %b", c, if_valid, exp_iv); end
         checks++; if (write_done !== exp_wd) begin errors++; $display("FAIL rnd_write_done c%0d: got %b want %b", c, write_done, exp_wd); end
         checks++; if (inst_stall !== (if_req && !exp_iv)) begin errors++; $display("FAIL rnd_inst_stall c%0d: got %b want %b", c, inst_stall, if_req && !exp_iv); end
         checks++; if (mem_stall !== (d_req && !exp_dv)) begin errors++; $display("FAIL rnd_mem_stall c%0d: got %b want %b", c, mem_stall, d_req && !exp_dv); end
         if (exp_mreq) begin
            checks++; if ({m_addr, m_we} !== {own_addr, own_we}) begin
               errors++; $display("FAIL rnd_m_addr c%0d: got %h/%b want %h/%b", c, m_addr, m_we, own_addr, own_we);
            end
            if (own_we) begin
               checks++; if (m_wdata !== own_wdata) begin errors++; $display("FAIL rnd_m_wdata c%0d: got %h want %h", c, m_wdata, own_wdata); end
            end
         end
         if (exp_dv && !own_we) begin
            checks++; if (d_rdata !== ref_mem[own_addr[3:0]]) begin errors++; $display("FAIL rnd_d_rdata c%0d: got %h want %h", c, d_rdata, ref_mem[own_addr[3:0]]); end
         end
         if (exp_iv) begin
            checks++; if (if_rdata !== ref_mem[own_addr[3:0]]) begin errors++; $display("FAIL rnd_if_rdata c%0d: got %h want %h", c, if_rdata, ref_mem[own_addr[3:0]]); end
         end
         if (exp_wd) ref_mem[own_addr[3:0]] = own_wdata;
         last_if_done = exp_iv;
         last_d_done  = exp_dv;
         last_flush   = if_flush;
         case (owner)
            O_NONE: begin
               if (d_req) begin
                  owner = O_DATA; own_addr = d_addr; own_we = d_we; own_wdata = d_wdata;
               end else if (if_req && !if_flush) begin
                  owner = O_FETCH; own_addr = if_addr; own_we = 1'b0;
               end
            end
            O_DATA:  if (m_ack) owner = O_NONE;
            O_FETCH: begin
               if (m_ack) owner = O_NONE;
               else if (if_flush) owner = O_DRAIN;
            end
            default: if (m_ack) owner = O_NONE;
         endcase
      end
      step();
      if_req = 1'b0; d_req = 1'b0; if_flush = 1'b0; m_ack = 1'b0;
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_simultaneous();
      test_store();
      test_flush();
      test_reset_mid();
      test_timeout();
      test_random(400);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
